prog_seq: RTL and testbench

Run sequencer for the 9-bit core. It accepts a host program request over a 4-phase req/done handshake and selects one of NPROG program entry points in instruction ROM. It loads that entry into the program counter, enables the core until it halts or a watchdog expires, then reports completion, timeout and cycle count. It sits between the host/testbench and the PC/control path, and holds the core in reset while idle.

---
 rtl/prog_seq.sv | 172 +++++++++++++++++
 tb/tb_prog_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_seq.sv
// prog_seq: run sequencer for the 9-bit core.
//
// It accepts a host run request on a 4-phase req/done handshake and picks one
// of NPROG program entry points. It then loads that entry into the PC, enables
// the core until it halts or the watchdog expires, and finally reports
// completion, timeout and the RUN cycle count. While idle the core is held in
// reset.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   req        in   host run request (level, 4-phase)
//   prog_sel   in   program index, sampled on the IDLE->LOAD edge
//   halt       in   core halt decode, meaningful while core_en=1
//   core_rst   out  holds core state/PC in reset (IDLE)
//   core_en    out  core advance enable (RUN)
//   ld_pc      out  one-cycle PC load strobe (LOAD)
//   start_addr out  entry address presented with ld_pc
//   busy       out  sequencer in LOAD or RUN
//   done       out  run complete, held until req drops
//   timeout    out  run ended by watchdog, valid while done=1
//   cycles     out  RUN cycles counted for the last or current run
module prog_seq #(
  parameter int D     = 12,
  parameter int NPROG = 4,
  parameter int CW    = 16,
  parameter int TMO   = 4000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [$clog2(NPROG)-1:0] prog_sel,
  input  logic                     halt,
  output logic                     core_rst,
  output logic                     core_en,
  output logic                     ld_pc,
  output logic [D-1:0]             start_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CW-1:0]            cycles
);

  localparam int SW = $clog2(NPROG);
  // Count value whose next RUN edge reaches the watchdog limit.
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cycles_r;
  logic [CW-1:0]   cycles_s;
  logic            timeout_r;
  logic            timeout_s;
  logic [D-1:0]    start_addr_r;
  logic [D-1:0]    start_addr_s;
  logic            core_rst_r;
  logic            core_en_r;
  logic            ld_pc_r;
  logic            busy_r;
  logic            done_r;
  logic            core_rst_s;
  logic            core_en_s;
  logic            ld_pc_s;
  logic            busy_s;
  logic            done_s;

  // Next-state, counter, watchdog and entry-address logic.
  always_comb begin
    state_s      = state_r;
    cycles_s     = cycles_r;
    timeout_s    = timeout_r;
    start_addr_s = start_addr_r;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          state_s   = S_LOAD;
          cycles_s  = {CW{1'b0}};
          timeout_s = 1'b0;
          // Entry regions are equal power-of-two slices of the PC space, so
          // the index simply becomes the top address bits.
          start_addr_s = {prog_sel, {(D-SW){1'b0}}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (req) begin
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        // Counts every RUN edge, including the one that leaves RUN.
        cycles_s = cycles_r + CW'(1);
        if (!req) begin
          state_s = S_IDLE;
        end else if (halt) begin
          state_s   = S_DONE;
          timeout_s = 1'b0;
        end else if (cycles_r == TMO_LAST) begin
          state_s   = S_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        if (!req) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state so the outputs can be registered
  // while still lining up with the state they describe.
  always_comb begin
    core_rst_s = (state_s == S_IDLE);
    core_en_s  = (state_s == S_RUN);
    ld_pc_s    = (state_s == S_LOAD);
    busy_s     = (state_s == S_LOAD) || (state_s == S_RUN);
    done_s     = (state_s == S_DONE);
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cycles_r     <= {CW{1'b0}};
      timeout_r    <= 1'b0;
      start_addr_r <= {D{1'b0}};
      core_rst_r   <= 1'b1;
      core_en_r    <= 1'b0;
      ld_pc_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cycles_r     <= cycles_s;
      timeout_r    <= timeout_s;
      start_addr_r <= start_addr_s;
      core_rst_r   <= core_rst_s;
      core_en_r    <= core_en_s;
      ld_pc_r      <= ld_pc_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign core_rst   = core_rst_r;
  assign core_en    = core_en_r;
  assign ld_pc      = ld_pc_r;
  assign start_addr = start_addr_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign timeout    = timeout_r;
  assign cycles     = cycles_r;

endmodule

// File: tb/tb_prog_seq.sv
// tb_prog_seq: directed self-checking bench for prog_seq.
// Flag vector order: {core_rst, core_en, ld_pc, busy, done, timeout}.
module tb_prog_seq;

  localparam int D     = 12;
  localparam int NPROG = 4;
  localparam int CW    = 16;
  localparam int TMO   = 8;

  logic          clk;
  logic          reset;
  logic          req;
  logic [1:0]    prog_sel;
  logic          halt;
  logic          core_rst;
  logic          core_en;
  logic          ld_pc;
  logic [D-1:0]  start_addr;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;

  int checks;
  int errors;

  prog_seq #(.D(D), .NPROG(NPROG), .CW(CW), .TMO(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .prog_sel   (prog_sel),
    .halt       (halt),
    .core_rst   (core_rst),
    .core_en    (core_en),
    .ld_pc      (ld_pc),
    .start_addr (start_addr),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] flags();
    return {core_rst, core_en, ld_pc, busy, done, timeout};
  endfunction

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a run; returns after the LOAD cycle has started.
  task automatic go(input logic [1:0] sel);
    prog_sel = sel;
    req = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req = 1'b0; halt = 1'b0; prog_sel = 2'd0; reset = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (flags() !== 6'b100000) begin
      errors++; $display("FAIL reset_flags got %b want %b", flags(), 6'b100000);
    end
    checks++;
    if (cycles !== 16'd0 || start_addr !== 12'd0) begin
      errors++; $display("FAIL reset_data got cyc=%0d addr=%0d want 0 0", cycles, start_addr);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (flags() !== 6'b100000 || cycles !== 16'd0) begin
        errors++; $display("FAIL idle_hold[%0d] got %b cyc=%0d want 100000 cyc=0", i, flags(), cycles);
      end
    end
  endtask

  task automatic test_normal_run();
    go(2'd2);
    checks++;
    if (flags() !== 6'b001100 || start_addr !== 12'd2048) begin
      errors++; $display("FAIL load got %b addr=%0d want 001100 addr=2048", flags(), start_addr);
    end
    prog_sel = 2'd3;  // ignored outside the IDLE->LOAD edge
    tick();
    checks++;
    if (flags() !== 6'b010100 || cycles !== 16'd0 || start_addr !== 12'd2048) begin
      errors++; $display("FAIL run_entry got %b cyc=%0d addr=%0d want 010100 0 2048", flags(), cycles, start_addr);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (flags() !== 6'b010100 || cycles !== CW'(i)) begin
        errors++; $display("FAIL run_count[%0d] got %b cyc=%0d want 010100 cyc=%0d", i, flags(), cycles, i);
      end
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (flags() !== 6'b000010 || cycles !== 16'd5) begin
      errors++; $display("FAIL halt_done got %b cyc=%0d want 000010 cyc=5", flags(), cycles);
    end
    req = 1'b0;
    tick();
    checks++;
    if (flags() !== 6'b100000 || cycles !== 16'd5) begin
      errors++; $display("FAIL done_release got %b cyc=%0d want 100000 cyc=5", flags(), cycles);
    end
  endtask

  task automatic test_watchdog();
    go(2'd1);
    checks++;
    if (ld_pc !== 1'b1 || start_addr !== 12'd1024) begin
      errors++; $display("FAIL wd_load got ld=%b addr=%0d want 1 1024", ld_pc, start_addr);
    end
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (flags() !== 6'b010100 || cycles !== CW'(i)) begin
        errors++; $display("FAIL wd_run[%0d] got %b cyc=%0d want 010100 cyc=%0d", i, flags(), cycles, i);
      end
    end
    tick();
    checks++;
    if (flags() !== 6'b000011 || cycles !== 16'd8) begin
      errors++; $display("FAIL wd_expire got %b cyc=%0d want 000011 cyc=8", flags(), cycles);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_halt_vs_watchdog();
    go(2'd0);
    checks++;
    if (flags() !== 6'b001100 || start_addr !== 12'd0 || cycles !== 16'd0) begin
      errors++; $display("FAIL hw_load got %b addr=%0d cyc=%0d want 001100 0 0", flags(), start_addr, cycles);
    end
    tick();
    for (int i = 0; i < 7; i++) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (flags() !== 6'b000010 || cycles !== 16'd8) begin
      errors++; $display("FAIL hw_tie got %b cyc=%0d want 000010 cyc=8", flags(), cycles);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    go(2'd3);
    checks++;
    if (start_addr !== 12'd3072) begin
      errors++; $display("FAIL ab_addr got %0d want 3072", start_addr);
    end
    tick();
    tick();
    tick();
    req = 1'b0;
    tick();
    checks++;
    if (flags() !== 6'b100000 || cycles !== 16'd3) begin
      errors++; $display("FAIL ab_run got %b cyc=%0d want 100000 cyc=3", flags(), cycles);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || cycles !== 16'd3) begin
        errors++; $display("FAIL ab_idle[%0d] got done=%b cyc=%0d want 0 3", i, done, cycles);
      end
    end
    // Abort straight out of LOAD.
    go(2'd1);
    req = 1'b0;
    tick();
    checks++;
    if (flags() !== 6'b100000 || cycles !== 16'd0) begin
      errors++; $display("FAIL ab_load got %b cyc=%0d want 100000 cyc=0", flags(), cycles);
    end
  endtask

  task automatic test_held_req();
    go(2'd0);
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (flags() !== 6'b000010 || cycles !== 16'd1) begin
      errors++; $display("FAIL hr_done got %b cyc=%0d want 000010 cyc=1", flags(), cycles);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (flags() !== 6'b000010 || cycles !== 16'd1) begin
        errors++; $display("FAIL hr_hold[%0d] got %b cyc=%0d want 000010 cyc=1", i, flags(), cycles);
      end
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    go(2'd1);
    tick();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (cycles !== 16'd4 || core_en !== 1'b1) begin
      errors++; $display("FAIL rm_pre got cyc=%0d en=%b want 4 1", cycles, core_en);
    end
    #2;
    reset = 1'b1;
    prog_sel = 2'd3;
    #1;
    checks++;
    if (flags() !== 6'b100000 || cycles !== 16'd0 || start_addr !== 12'd0) begin
      errors++; $display("FAIL rm_async got %b cyc=%0d addr=%0d want 100000 0 0", flags(), cycles, start_addr);
    end
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if (flags() !== 6'b001100 || start_addr !== 12'd3072) begin
      errors++; $display("FAIL rm_reload got %b addr=%0d want 001100 3072", flags(), start_addr);
    end
    tick();
    checks++;
    if (flags() !== 6'b010100 || cycles !== 16'd0) begin
      errors++; $display("FAIL rm_run got %b cyc=%0d want 010100 0", flags(), cycles);
    end
    req = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal_run();
    test_watchdog();
    test_halt_vs_watchdog();
    test_abort();
    test_held_req();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
